// File: rtl/btn_conditioner.sv
// btn_conditioner: per-button 2-flop synchronizer, counter-based debounce FSM,
// debounced level and single-cycle press/release pulses.
// Optional feature macro BTN_AUTOREPEAT_EN: extra press pulses while a button
// is held (first after RPT_DELAY cycles, then every RPT_PERIOD cycles).
module btn_conditioner #(
    parameter int unsigned N_BTN      = 2,
    parameter int unsigned DB_CYCLES  = 1_000_000
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int unsigned RPT_DELAY  = 50_000_000,
    parameter int unsigned RPT_PERIOD = 10_000_000
`endif
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release
);

    // Counter width covers the largest terminal count in this build.
`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned MAX_CYC = (RPT_DELAY > DB_CYCLES) ? RPT_DELAY : DB_CYCLES;
`else
    localparam int unsigned MAX_CYC = DB_CYCLES;
`endif
    localparam int unsigned CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DB_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RPT_LAST   = CNT_W'(RPT_DELAY - 1);
    // Reloading here puts the next terminal compare RPT_PERIOD cycles away.
    localparam logic [CNT_W-1:0] RPT_RELOAD = CNT_W'(RPT_DELAY - RPT_PERIOD);
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM_P   = 2'd1,
        PRESSED = 2'd2,
        ARM_R   = 2'd3
    } state_t;

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync_q;

    // Two-flop synchronizer; the debounce FSMs only ever see sync_q.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= '0;
            sync_q  <= '0;
        end else begin
            sync1_q <= i_btn;
            sync_q  <= sync1_q;
        end
    end

    for (genvar g = 0; g < int'(N_BTN); g++) begin : g_btn
        state_t           state_q;
        state_t           state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             press_d;
        logic             release_d;
        logic             level_d;
        logic             press_q;
        logic             release_q;
        logic             level_q;
`ifdef BTN_AUTOREPEAT_EN
        logic [CNT_W-1:0] rpt_q;
        logic [CNT_W-1:0] rpt_d;
`endif

        // State and counter registers.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                state_q <= IDLE;
                cnt_q   <= '0;
`ifdef BTN_AUTOREPEAT_EN
                rpt_q   <= '0;
`endif
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
`ifdef BTN_AUTOREPEAT_EN
                rpt_q   <= rpt_d;
`endif
            end
        end

        // Debounce next-state, counter updates and pulse requests.
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            press_d   = 1'b0;
            release_d = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rpt_d     = rpt_q;
`endif
            case (state_q)
                IDLE: begin
                    if (sync_q[g]) begin
                        state_d = ARM_P;
                        cnt_d   = '0;
                    end
                end
                ARM_P: begin
                    if (!sync_q[g]) begin
                        state_d = IDLE;
                    end else if (cnt_q == DB_LAST) begin
                        state_d = PRESSED;
                        press_d = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        rpt_d   = '0;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!sync_q[g]) begin
                        state_d = ARM_R;
                        cnt_d   = '0;
                    end
`ifdef BTN_AUTOREPEAT_EN
                    // Repeat timer advances only while the press is stable.
                    else if (rpt_q == RPT_LAST) begin
                        press_d = 1'b1;
                        rpt_d   = RPT_RELOAD;
                    end else begin
                        rpt_d = rpt_q + CNT_W'(1);
                    end
`endif
                end
                ARM_R: begin
                    if (sync_q[g]) begin
                        state_d = PRESSED;
                    end else if (cnt_q == DB_LAST) begin
                        state_d   = IDLE;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
            level_d = (state_d == PRESSED) || (state_d == ARM_R);
        end

        // Registered outputs.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                level_q   <= 1'b0;
            end else begin
                press_q   <= press_d;
                release_q <= release_d;
                level_q   <= level_d;
            end
        end

        assign o_press[g]   = press_q;
        assign o_release[g] = release_q;
        assign o_level[g]   = level_q;
    end

endmodule
